dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory (word-addressed, combinational read, level-sensitive write). It grants one of two requesters (port 0: load/store unit, port 1: debug/DMA loader) per transaction with round-robin fairness. It drives the memory's ADDR/RW/WD from registers so the write strobe is glitch-free and exactly one cycle long. Read data is captured into a register and returned with a one-cycle ACK.

## Interface
- MEM_BYTES, 1024: byte size of the memory; the range-check limit.
- AW, 32: address width.
- DW, 32: data width.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- REQ0 / REQ1  in  1  request; held high with WEn/ADDRn/WDn stable until ACKn.
- WE0 / WE1  in  1  1 = write, 0 = read.
- ADDR0 / ADDR1  in  AW  byte address.
- WD0 / WD1  in  DW  write data.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RDATA  out  DW  read data, valid only in the ACK cycle; shared by both ports.
- ERR  out  1  valid only in the ACK cycle; access rejected.
- MEM_ADDR  out  AW  to memory ADDR, registered.
- MEM_RW  out  1  to memory RW, registered; 1 only in a write ACCESS cycle.
- MEM_WD  out  DW  to memory WD, registered.
- MEM_RD  in  DW  from memory RD.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any REQ is high, pick a port and latch its WE/ADDR/WD into MEM_RW/MEM_ADDR/MEM_WD, then go to ACCESS.
  - Otherwise stay in IDLE with MEM_RW=0.
- Arbitration:
  - With one request, that port wins.
  - With both requests, the port not granted last wins.
  - The last-grant pointer is 1 after reset, so port 0 wins the first tie.
  - The pointer updates on every grant.
- ACCESS (exactly 1 cycle):
  - Memory is driven.
  - Read: capture MEM_RD into RDATA at the end of the cycle.
  - Write: MEM_RW=1 for this cycle only, and RDATA is loaded with 0.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - ACK of the granted port = 1; the other ACK = 0.
  - MEM_RW=0; MEM_ADDR and MEM_WD hold their values.
  - Go to IDLE.
- A port may keep REQ high after ACK to issue its next access. It is then re-arbitrated in IDLE.
- A REQ dropped before ACK is a protocol violation; the latched transaction still completes.
- RST takes priority over everything:
  - Reset values: state=IDLE, ACK0=ACK1=0, ERR=0, RDATA=0, MEM_ADDR=0, MEM_WD=0, MEM_RW=0, pointer=1.
  - RST asserted during ACCESS of a write: the write may already have landed (memory is level-sensitive). No ACK is issued.

## Timing
- Request seen high at edge k (state IDLE) → ACCESS during cycle k..k+1 → ACKn high during cycle k+1..k+2.
- Per-transaction latency: 2 cycles from grant edge to ACK.
- Throughput: one transaction per 3 cycles (IDLE, ACCESS, RESP).
- Back-to-back from the same port while both request: the ports alternate, P0, P1, P0, …
- MEM_RW rises and falls only on CLK edges; MEM_ADDR and MEM_WD are stable the whole cycle MEM_RW=1.

## Configuration
- DMEM_ARB_RANGE_CHK_EN defined:
  - In IDLE, a granted request with ADDR ≥ MEM_BYTES or ADDR[1:0] ≠ 0 is rejected.
  - A rejected request still goes through ACCESS, but with MEM_RW forced 0.
  - In RESP: ACK=1, ERR=1, RDATA=0.
  - The rejected request still consumes its arbitration turn.
- DMEM_ARB_RANGE_CHK_EN undefined:
  - No check is made; ERR is tied 0.
  - Every request goes to memory; the memory itself ignores out-of-range writes.

## Structure
- Package dmem_arb_pkg holds:
  - the state encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10;
  - default widths AW/DW;
  - the MEM_BYTES default.
- Sub-module rr_pick2: inputs req[1:0] and last; outputs a one-hot grant[1:0] and valid. It is purely combinational and instantiated once.

## Test plan
- Reset, then REQ0=1, WE0=1, ADDR0=0x10, WD0=0xDEADBEEF → MEM_RW high for exactly one cycle with MEM_ADDR=0x10; ACK0 two cycles after grant; RDATA=0.
- Read-back: REQ0=1, WE0=0, ADDR0=0x10 → ACK0 with RDATA=0xDEADBEEF and ERR=0; MEM_RW stays 0 throughout.
- REQ0 and REQ1 both held high for 4 transactions → grant order P0, P1, P0, P1; ACK0 and ACK1 are never high in the same cycle.
- With DMEM_ARB_RANGE_CHK_EN: write to ADDR1=0x400, then write to ADDR1=0x6 → each gets ACK1=1, ERR=1; MEM_RW never rises; memory contents unchanged.
- RST pulsed during the ACCESS cycle of a P1 read → no ACK1; all outputs at reset values next cycle; the next REQ0/REQ1 tie grants P0.
- REQ1 held high continuously with REQ0 idle → one transaction every 3 cycles, each ending in an ACK1 pulse.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// State encoding plus default address/data widths and memory size.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam int AW_DEF        = 32;
    localparam int DW_DEF        = 32;
    localparam int MEM_BYTES_DEF = 1024;

endpackage

// File: rtl/dmem_arb_rr_pick2.sv
// Two-way round-robin pick: one-hot grant, favouring the port not
// granted last when both request.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for a single-port data memory.
// Optional address range check: DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WD0,
    input  logic [DW-1:0] WD1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic          ERR,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_RW,
    output logic [DW-1:0] MEM_WD,
    input  logic [DW-1:0] MEM_RD
);

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    grant;
    logic          valid;
    logic          last_q;
    logic          sel_q;
    logic          err_q;
    logic          g_sel;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd;
    logic          bad;

    rr_pick2 u_pick (
        .req   ({REQ1, REQ0}),
        .last  (last_q),
        .grant (grant),
        .valid (valid)
    );

    assign g_sel  = grant[1];
    assign g_we   = g_sel ? WE1 : WE0;
    assign g_addr = g_sel ? ADDR1 : ADDR0;
    assign g_wd   = g_sel ? WD1 : WD0;

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign bad = (g_addr >= AW'(MEM_BYTES)) || (g_addr[1:0] != 2'b00);
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobe and bus come straight from flops so RW is glitch-free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MEM_ADDR <= '0;
            MEM_WD   <= '0;
            MEM_RW   <= 1'b0;
            RDATA    <= '0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid) begin
                        MEM_ADDR <= g_addr;
                        MEM_WD   <= g_wd;
                        MEM_RW   <= g_we & ~bad;
                        sel_q    <= g_sel;
                        last_q   <= g_sel;
                        err_q    <= bad;
                    end
                end
                ACCESS: begin
                    MEM_RW <= 1'b0;
                    RDATA  <= (MEM_RW | err_q) ? '0 : MEM_RD;
                end
                default: begin
                    MEM_RW <= 1'b0;
                end
            endcase
        end
    end

    assign ACK0 = (state_q == RESP) && !sel_q;
    assign ACK1 = (state_q == RESP) && sel_q;
    assign ERR  = (state_q == RESP) && err_q;

endmodule
